// File: rtl/ps_mac_pkg.sv
// Shared types, constants and helpers for the ps_mac_seq precision-scalable MAC.
package ps_mac_pkg;

  localparam int DIGIT_W = 2;
  localparam int PP_W    = 5;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  // Out-of-range lane modes collapse onto the widest lane the datapath supports.
  function automatic int unsigned clamp_mode(input int unsigned mode, input int unsigned max_m);
    return (mode > max_m) ? max_m : mode;
  endfunction

  // Clamp pattern for a w-bit signed accumulator; caller keeps the low w bits.
  function automatic logic [63:0] saturate(input logic neg, input int unsigned w);
    if (neg) saturate = ~64'd0 << (w - 1);
    else     saturate = (64'd1 << (w - 1)) - 64'd1;
  endfunction

endpackage

// File: rtl/ps_mac_seq_if.sv
// Operand/result bus of ps_mac_seq: input valid/ready handshake plus result strobe.
interface ps_mac_seq_if #(
    parameter int DIGITS = 4,
    parameter int ACC_W  = 24
);
    localparam int MODE_W = $clog2(DIGITS) + 1;

    // An operand pair transfers on a rising edge where in_valid and in_ready are both 1;
    // in_valid must not depend on in_ready, and operands are ignored while in_ready is 0.
    logic                  in_valid;
    logic                  in_ready;
    logic [MODE_W-1:0]     mode;
    logic                  sa;
    logic                  sb;
    logic [2*DIGITS-1:0]   a;
    logic [2*DIGITS-1:0]   b;
    logic                  acc_clr;
    logic [ACC_W-1:0]      acc_out;
    logic                  out_valid;
    logic                  ovf;

    modport master (
        output in_valid, mode, sa, sb, a, b, acc_clr,
        input  in_ready, acc_out, out_valid, ovf
    );

    modport slave (
        input  in_valid, mode, sa, sb, a, b, acc_clr,
        output in_ready, acc_out, out_valid, ovf
    );
endinterface

// File: rtl/ps_digit_mul.sv
// Signed 2-bit x 2-bit digit product; ext flags supply the third (sign) bit of each digit.
module ps_digit_mul
    import ps_mac_pkg::*;
(
    input  logic [DIGIT_W-1:0]      a_i,
    input  logic [DIGIT_W-1:0]      b_i,
    input  logic                    ext_a_i,
    input  logic                    ext_b_i,
    output logic signed [PP_W-1:0]  p_o
);
    logic signed [PP_W-1:0] ax;
    logic signed [PP_W-1:0] bx;

    // The 3-bit digit {ext, d} sign-extended straight to the product width.
    assign ax  = {{(PP_W-DIGIT_W){ext_a_i}}, a_i};
    assign bx  = {{(PP_W-DIGIT_W){ext_b_i}}, b_i};
    assign p_o = ax * bx;
endmodule

// File: rtl/ps_mac_seq.sv
// Sequential precision-scalable MAC: one multiplier digit per cycle into a signed accumulator.
// Define PSMAC_SAT_EN to clamp the accumulator on signed overflow instead of wrapping.
module ps_mac_seq
    import ps_mac_pkg::*;
#(
    parameter int DIGITS = 4,
    parameter int ACC_W  = 24
) (
    input  logic         clk,
    input  logic         rst_n,
    ps_mac_seq_if.slave  bus,
    output state_t       dbg_state_o
);
    localparam int OP_W   = 2 * DIGITS;
    localparam int LOG_D  = $clog2(DIGITS);
    localparam int MODE_W = LOG_D + 1;
    localparam int KW     = (DIGITS > 1) ? LOG_D : 1;
    localparam int NMUL   = DIGITS * DIGITS;

    state_t                    state_q, state_d;
    logic [OP_W-1:0]           a_q, a_d, b_q, b_d;
    logic                      sa_q, sa_d, sb_q, sb_d, clr_q, clr_d;
    logic [MODE_W-1:0]         m_q, m_d;
    logic [KW-1:0]             k_q, k_d;
    logic signed [ACC_W-1:0]   acc_q, acc_d;
    logic                      ovf_q, ovf_d, ov_q, ov_d;

    logic [DIGIT_W-1:0]        ad [NMUL];
    logic [DIGIT_W-1:0]        bd [NMUL];
    logic [NMUL-1:0]           ext_a, ext_b;
    logic signed [PP_W-1:0]    pp [NMUL];
    logic signed [ACC_W-1:0]   addend, term, base;
    logic signed [ACC_W:0]     sum_w;
    logic                      add_ovf;
    int                        dpl;
`ifdef PSMAC_SAT_EN
    logic [63:0]               sat_v;
`endif

    assign dpl = 1 << m_q;

    // Multiplier (j, jj) pairs a digit j with b digit jj; it is live only when both sit in
    // the same lane and jj is that lane's k-th digit, so masked pairs multiply zeros.
    always_comb begin
        for (int j = 0; j < DIGITS; j++) begin
            for (int jj = 0; jj < DIGITS; jj++) begin
                int  idx;
                logic en;
                idx = j * DIGITS + jj;
                en  = (state_q == BUSY) && ((j >> m_q) == (jj >> m_q))
                      && ((jj & (dpl - 1)) == int'(k_q));
                ad[idx]    = en ? a_q[DIGIT_W*j +: DIGIT_W]  : '0;
                bd[idx]    = en ? b_q[DIGIT_W*jj +: DIGIT_W] : '0;
                ext_a[idx] = en && sa_q && a_q[DIGIT_W*j+1]  && ((j & (dpl - 1)) == dpl - 1);
                ext_b[idx] = en && sb_q && b_q[DIGIT_W*jj+1] && (int'(k_q) == dpl - 1);
            end
        end
    end

    for (genvar g = 0; g < NMUL; g++) begin : g_mul
        ps_digit_mul u_mul (
            .a_i     (ad[g]),
            .b_i     (bd[g]),
            .ext_a_i (ext_a[g]),
            .ext_b_i (ext_b[g]),
            .p_o     (pp[g])
        );
    end

    always_comb begin
        addend = '0;
        term   = '0;
        for (int j = 0; j < DIGITS; j++) begin
            for (int jj = 0; jj < DIGITS; jj++) begin
                term   = {{(ACC_W-PP_W){pp[j*DIGITS+jj][PP_W-1]}}, pp[j*DIGITS+jj]};
                addend = addend + (term << (DIGIT_W * ((j & (dpl - 1)) + int'(k_q))));
            end
        end
    end

    assign base    = (clr_q && (k_q == '0)) ? '0 : acc_q;
    assign sum_w   = {base[ACC_W-1], base} + {addend[ACC_W-1], addend};
    assign add_ovf = sum_w[ACC_W] != sum_w[ACC_W-1];

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        clr_d   = clr_q;
        m_d     = m_q;
        k_d     = k_q;
        acc_d   = acc_q;
        ovf_d   = ovf_q;
        ov_d    = 1'b0;
`ifdef PSMAC_SAT_EN
        sat_v   = saturate(base[ACC_W-1], ACC_W);
`endif
        unique case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    a_d     = bus.a;
                    b_d     = bus.b;
                    sa_d    = bus.sa;
                    sb_d    = bus.sb;
                    clr_d   = bus.acc_clr;
                    m_d     = MODE_W'(clamp_mode(32'(bus.mode), LOG_D));
                    k_d     = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
`ifdef PSMAC_SAT_EN
                acc_d = add_ovf ? sat_v[ACC_W-1:0] : sum_w[ACC_W-1:0];
`else
                acc_d = sum_w[ACC_W-1:0];
`endif
                ovf_d = ((clr_q && (k_q == '0)) ? 1'b0 : ovf_q) | add_ovf;
                if (int'(k_q) == dpl - 1) begin
                    ov_d    = 1'b1;
                    state_d = IDLE;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
            clr_q   <= 1'b0;
            m_q     <= '0;
            k_q     <= '0;
            acc_q   <= '0;
            ovf_q   <= 1'b0;
            ov_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            clr_q   <= clr_d;
            m_q     <= m_d;
            k_q     <= k_d;
            acc_q   <= acc_d;
            ovf_q   <= ovf_d;
            ov_q    <= ov_d;
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.acc_out   = acc_q;
    assign bus.out_valid = ov_q;
    assign bus.ovf       = ovf_q;
    assign dbg_state_o   = state_q;
endmodule

// File: tb/tb_ps_mac_seq.sv
// Directed bench for ps_mac_seq: a 24-bit accumulator instance plus a 16-bit one for overflow.
module tb_ps_mac_seq;
  import ps_mac_pkg::*;

  logic clk;
  logic rst_n;
  state_t st_a, st_b;
  int n_vec;
  int n_err;
  logic [23:0] exp_q[$];

  ps_mac_seq_if #(.DIGITS(4), .ACC_W(24)) ifa ();
  ps_mac_seq_if #(.DIGITS(4), .ACC_W(16)) ifb ();

  ps_mac_seq #(.DIGITS(4), .ACC_W(24)) u_a (
    .clk(clk), .rst_n(rst_n), .bus(ifa.slave), .dbg_state_o(st_a)
  );
  ps_mac_seq #(.DIGITS(4), .ACC_W(16)) u_b (
    .clk(clk), .rst_n(rst_n), .bus(ifb.slave), .dbg_state_o(st_b)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver: offer one operation at a negedge, accept on the next posedge, then watch for done
  task automatic run_op(input bit sel, input logic [2:0] m, input logic s_a, input logic s_b,
                        input logic [7:0] op_a, input logic [7:0] op_b, input logic clr,
                        output int lat, output int busy_lo, output logic [23:0] res,
                        output logic ov);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!(sel ? ifb.in_ready : ifa.in_ready) && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (sel) begin
      ifb.mode = m; ifb.sa = s_a; ifb.sb = s_b; ifb.a = op_a; ifb.b = op_b;
      ifb.acc_clr = clr; ifb.in_valid = 1'b1;
    end else begin
      ifa.mode = m; ifa.sa = s_a; ifa.sb = s_b; ifa.a = op_a; ifa.b = op_b;
      ifa.acc_clr = clr; ifa.in_valid = 1'b1;
    end
    @(posedge clk);
    #1;
    ifa.in_valid = 1'b0;
    ifb.in_valid = 1'b0;
    lat = 0; busy_lo = 0; res = '0; ov = 1'b0;
    if (!(sel ? ifb.in_ready : ifa.in_ready)) busy_lo++;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk);
      #1;
      if (sel ? ifb.out_valid : ifa.out_valid) begin
        lat = c;
        res = sel ? 24'(ifb.acc_out) : ifa.acc_out;
        ov  = sel ? ifb.ovf : ifa.ovf;
        break;
      end
      if (!(sel ? ifb.in_ready : ifa.in_ready)) busy_lo++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    n_vec++; if (ifa.acc_out !== 24'h0) begin n_err++; $display("FAIL rst_acc got %h want 000000", ifa.acc_out); end
    n_vec++; if (ifa.out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid got %b want 0", ifa.out_valid); end
    n_vec++; if (ifa.ovf !== 1'b0) begin n_err++; $display("FAIL rst_ovf got %b want 0", ifa.ovf); end
    n_vec++; if (ifa.in_ready !== 1'b1) begin n_err++; $display("FAIL rst_in_ready got %b want 1", ifa.in_ready); end
    n_vec++; if (st_a !== IDLE) begin n_err++; $display("FAIL rst_state got %0d want IDLE", st_a); end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_mode0();
    int lat, bl; logic [23:0] r; logic ov;
    run_op(1'b0, 3'd0, 1'b1, 1'b1, 8'b11_01_10_01, 8'h55, 1'b1, lat, bl, r, ov);
    n_vec++; if (lat !== 1) begin n_err++; $display("FAIL m0_latency got %0d want 1", lat); end
    n_vec++; if (r !== 24'hFFFFFF) begin n_err++; $display("FAIL m0_acc got %h want ffffff", r); end
    n_vec++; if (bl !== 1) begin n_err++; $display("FAIL m0_busy got %0d want 1", bl); end
    @(posedge clk); #1;
    n_vec++; if (ifa.out_valid !== 1'b0) begin n_err++; $display("FAIL m0_pulse got %b want 0", ifa.out_valid); end
    n_vec++; if (ifa.acc_out !== 24'hFFFFFF) begin n_err++; $display("FAIL m0_hold got %h want ffffff", ifa.acc_out); end
  endtask

  task automatic test_mode2();
    int lat, bl; logic [23:0] r; logic ov;
    run_op(1'b0, 3'd2, 1'b1, 1'b1, 8'h80, 8'h80, 1'b1, lat, bl, r, ov);
    n_vec++; if (lat !== 4) begin n_err++; $display("FAIL m2_latency got %0d want 4", lat); end
    n_vec++; if (bl !== 4) begin n_err++; $display("FAIL m2_busy got %0d want 4", bl); end
    n_vec++; if (r !== 24'd16384) begin n_err++; $display("FAIL m2_acc got %0d want 16384", r); end
    n_vec++; if (ov !== 1'b0) begin n_err++; $display("FAIL m2_ovf got %b want 0", ov); end
  endtask

  task automatic test_accumulate();
    int lat, bl; logic [23:0] r, e; logic ov;
    exp_q.push_back(24'd30);
    exp_q.push_back(24'd60);
    for (int i = 0; i < 2; i++) begin
      run_op(1'b0, 3'd1, 1'b0, 1'b0, 8'hFF, 8'h11, (i == 0), lat, bl, r, ov);
      e = exp_q.pop_front();
      n_vec++; if (r !== e) begin n_err++; $display("FAIL acc_%0d got %0d want %0d", i, r, e); end
      n_vec++; if (lat !== 2) begin n_err++; $display("FAIL acc_lat_%0d got %0d want 2", i, lat); end
    end
  endtask

  task automatic test_mixed_sign();
    int lat, bl; logic [23:0] r; logic ov;
    // lanes: a = {-1, 0} signed, b = {5, 3} unsigned -> -5
    run_op(1'b0, 3'd1, 1'b1, 1'b0, 8'hF0, 8'h53, 1'b1, lat, bl, r, ov);
    n_vec++; if (r !== 24'hFFFFFB) begin n_err++; $display("FAIL mixed_acc got %h want fffffb", r); end
    n_vec++; if (ov !== 1'b0) begin n_err++; $display("FAIL mixed_ovf got %b want 0", ov); end
  endtask

  task automatic test_mode_clamp();
    int lat, bl; logic [23:0] r; logic ov;
    run_op(1'b0, 3'd7, 1'b1, 1'b1, 8'h80, 8'h80, 1'b1, lat, bl, r, ov);
    n_vec++; if (lat !== 4) begin n_err++; $display("FAIL clamp_latency got %0d want 4", lat); end
    n_vec++; if (r !== 24'd16384) begin n_err++; $display("FAIL clamp_acc got %0d want 16384", r); end
  endtask

  task automatic test_back_to_back();
    int acc_cyc[$];
    int pulses, dbl;
    logic prev;
    pulses = 0; dbl = 0; prev = 1'b0;
    @(negedge clk);
    ifa.mode = 3'd2; ifa.sa = 1'b0; ifa.sb = 1'b0; ifa.a = 8'h03; ifa.b = 8'h02;
    ifa.acc_clr = 1'b1; ifa.in_valid = 1'b1;
    for (int c = 0; c < 25; c++) begin
      if (c > 0) @(negedge clk);
      if (ifa.in_ready) acc_cyc.push_back(c);
      @(posedge clk); #1;
      if (ifa.out_valid) pulses++;
      if (ifa.out_valid && prev) dbl++;
      prev = ifa.out_valid;
    end
    @(negedge clk);
    ifa.in_valid = 1'b0;
    n_vec++; if (acc_cyc.size() !== 5) begin n_err++; $display("FAIL b2b_accepts got %0d want 5", acc_cyc.size()); end
    for (int i = 1; i < acc_cyc.size(); i++) begin
      n_vec++;
      if (acc_cyc[i] - acc_cyc[i-1] !== 5) begin
        n_err++; $display("FAIL b2b_gap_%0d got %0d want 5", i, acc_cyc[i] - acc_cyc[i-1]);
      end
    end
    n_vec++; if (pulses !== 5) begin n_err++; $display("FAIL b2b_pulses got %0d want 5", pulses); end
    n_vec++; if (dbl !== 0) begin n_err++; $display("FAIL b2b_wide_pulse got %0d want 0", dbl); end
    n_vec++; if (ifa.acc_out !== 24'd6) begin n_err++; $display("FAIL b2b_acc got %0d want 6", ifa.acc_out); end
  endtask

  task automatic test_reset_mid();
    bit seen;
    seen = 1'b0;
    @(negedge clk);
    ifa.mode = 3'd2; ifa.sa = 1'b1; ifa.sb = 1'b1; ifa.a = 8'h80; ifa.b = 8'h80;
    ifa.acc_clr = 1'b1; ifa.in_valid = 1'b1;
    @(posedge clk); #1;
    ifa.in_valid = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    n_vec++; if (ifa.acc_out !== 24'h0) begin n_err++; $display("FAIL midrst_acc got %h want 000000", ifa.acc_out); end
    n_vec++; if (ifa.in_ready !== 1'b1) begin n_err++; $display("FAIL midrst_ready got %b want 1", ifa.in_ready); end
    n_vec++; if (st_a !== IDLE) begin n_err++; $display("FAIL midrst_state got %0d want IDLE", st_a); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      if (ifa.out_valid) seen = 1'b1;
    end
    n_vec++; if (seen !== 1'b0) begin n_err++; $display("FAIL midrst_out_valid got %b want 0", seen); end
    n_vec++; if (ifa.in_ready !== 1'b1) begin n_err++; $display("FAIL midrst_ready_after got %b want 1", ifa.in_ready); end
    n_vec++; if (ifa.acc_out !== 24'h0) begin n_err++; $display("FAIL midrst_acc_after got %h want 000000", ifa.acc_out); end
  endtask

  task automatic test_overflow();
    int lat, bl; logic [23:0] r; logic ov;
    logic [15:0] e2, e3;
`ifdef PSMAC_SAT_EN
    e2 = 16'h7FFF; e3 = 16'h7FFF;
`else
    e2 = 16'h8000; e3 = 16'h8001;
`endif
    run_op(1'b1, 3'd2, 1'b1, 1'b1, 8'h80, 8'h80, 1'b1, lat, bl, r, ov);
    n_vec++; if (r[15:0] !== 16'h4000) begin n_err++; $display("FAIL ovf_first got %h want 4000", r[15:0]); end
    n_vec++; if (ov !== 1'b0) begin n_err++; $display("FAIL ovf_first_flag got %b want 0", ov); end
    run_op(1'b1, 3'd2, 1'b1, 1'b1, 8'h80, 8'h80, 1'b0, lat, bl, r, ov);
    n_vec++; if (r[15:0] !== e2) begin n_err++; $display("FAIL ovf_second got %h want %h", r[15:0], e2); end
    n_vec++; if (ov !== 1'b1) begin n_err++; $display("FAIL ovf_second_flag got %b want 1", ov); end
    run_op(1'b1, 3'd2, 1'b0, 1'b0, 8'h01, 8'h01, 1'b0, lat, bl, r, ov);
    n_vec++; if (r[15:0] !== e3) begin n_err++; $display("FAIL ovf_third got %h want %h", r[15:0], e3); end
    n_vec++; if (ov !== 1'b1) begin n_err++; $display("FAIL ovf_sticky got %b want 1", ov); end
    run_op(1'b1, 3'd2, 1'b0, 1'b0, 8'h01, 8'h01, 1'b1, lat, bl, r, ov);
    n_vec++; if (r[15:0] !== 16'h0001) begin n_err++; $display("FAIL ovf_clr_acc got %h want 0001", r[15:0]); end
    n_vec++; if (ov !== 1'b0) begin n_err++; $display("FAIL ovf_clr_flag got %b want 0", ov); end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    ifa.in_valid = 1'b0; ifa.mode = '0; ifa.sa = 1'b0; ifa.sb = 1'b0;
    ifa.a = '0; ifa.b = '0; ifa.acc_clr = 1'b0;
    ifb.in_valid = 1'b0; ifb.mode = '0; ifb.sa = 1'b0; ifb.sb = 1'b0;
    ifb.a = '0; ifb.b = '0; ifb.acc_clr = 1'b0;
    test_reset();
    test_mode0();
    test_mode2();
    test_accumulate();
    test_mixed_sign();
    test_mode_clamp();
    test_back_to_back();
    test_reset_mid();
    test_overflow();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
